// File: rtl/dart_game_ctrl_pkg.sv
// Shared types and constants for the 301 dart scoring engine: controller states,
// ring radius-squared thresholds, ring classes and the octant sector values.
package dart_game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StScore,
    StUpdate,
    StGap,
    StOver
  } state_e;

  typedef enum logic [2:0] {
    RingMiss,
    RingSingle,
    RingDouble,
    RingTriple,
    RingBull25,
    RingBull50
  } ring_e;

  // Ring boundaries expressed as squared distance from the board centre
  localparam logic [16:0] R2Bull50   = 17'd1;
  localparam logic [16:0] R2Bull25   = 17'd4;
  localparam logic [16:0] R2TripleLo = 17'd36;
  localparam logic [16:0] R2TripleHi = 17'd49;
  localparam logic [16:0] R2DoubleLo = 17'd144;
  localparam logic [16:0] R2DoubleHi = 17'd169;

  function automatic logic [4:0] sector_value(input logic [2:0] octant);
    logic [4:0] value;
    value = 5'd0;
    unique case (octant)
      3'd0: value = 5'd20;
      3'd1: value = 5'd1;
      3'd2: value = 5'd6;
      3'd3: value = 5'd3;
      3'd4: value = 5'd19;
      3'd5: value = 5'd11;
      3'd6: value = 5'd14;
      3'd7: value = 5'd5;
      default: value = 5'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/dart_game_ctrl_if.sv
// Dart source <-> scoring engine bundle: hit coordinate in, pulses/points/flags out.
interface dart_game_ctrl_if;

  logic       dart_come_i;
  logic [7:0] dart_position_x_i;
  logic [7:0] dart_position_y_i;
  logic       game_set_o;
  logic       player_1_done_o;
  logic       player_2_done_o;
  logic       player_1_win_o;
  logic       player_2_win_o;
  logic [8:0] player_1_pt_o;
  logic [8:0] player_2_pt_o;

  modport master (
    output dart_come_i, dart_position_x_i, dart_position_y_i,
    input  game_set_o, player_1_done_o, player_2_done_o,
    input  player_1_win_o, player_2_win_o, player_1_pt_o, player_2_pt_o
  );

  modport slave (
    input  dart_come_i, dart_position_x_i, dart_position_y_i,
    output game_set_o, player_1_done_o, player_2_done_o,
    output player_1_win_o, player_2_win_o, player_1_pt_o, player_2_pt_o
  );

endinterface

// File: rtl/dart_score_lut.sv
// Combinational hit-to-points mapping: ring from squared radius, sector from octant.
// The is_double output only exists when DOUBLE_OUT_EN is defined.
module dart_score_lut
  import dart_game_pkg::*;
#(
  parameter int unsigned CX = 14,
  parameter int unsigned CY = 14
) (
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
`ifdef DOUBLE_OUT_EN
  output logic       o_is_double,
`endif
  output logic [5:0] o_score
);

  logic signed [8:0] w_dx;
  logic signed [8:0] w_dy;
  logic [8:0]        w_adx;
  logic [8:0]        w_ady;
  logic [16:0]       w_d2;
  logic              w_dx_pos;
  logic              w_dy_pos;
  logic [1:0]        w_quad;
  logic              w_even;
  logic [5:0]        w_base;
  ring_e             w_ring;

  // y grows downwards on the board, so dy is flipped
  assign w_dx  = $signed({1'b0, i_x}) - $signed(9'(CX));
  assign w_dy  = $signed(9'(CY)) - $signed({1'b0, i_y});
  assign w_adx = w_dx[8] ? 9'(-w_dx) : 9'(w_dx);
  assign w_ady = w_dy[8] ? 9'(-w_dy) : 9'(w_dy);
  assign w_d2  = 17'(w_adx) * 17'(w_adx) + 17'(w_ady) * 17'(w_ady);

  assign w_dx_pos = !w_dx[8] && (w_dx != 9'sd0);
  assign w_dy_pos = !w_dy[8] && (w_dy != 9'sd0);

  always_comb begin
    w_quad = 2'd3;
    if (!w_dx[8] && w_dy_pos) begin
      w_quad = 2'd0;
    end else if (w_dx_pos && !w_dy_pos) begin
      w_quad = 2'd1;
    end else if (!w_dx_pos && w_dy[8]) begin
      w_quad = 2'd2;
    end
  end

  // Even octant of a quadrant is the half nearer its leading axis
  assign w_even = w_quad[0] ? (w_adx > w_ady) : (w_ady > w_adx);
  assign w_base = {1'b0, sector_value({w_quad, !w_even})};

  always_comb begin
    w_ring = RingSingle;
    if (w_d2 <= R2Bull50) begin
      w_ring = RingBull50;
    end else if (w_d2 <= R2Bull25) begin
      w_ring = RingBull25;
    end else if (w_d2 > R2DoubleHi) begin
      w_ring = RingMiss;
    end else if (w_d2 >= R2TripleLo && w_d2 <= R2TripleHi) begin
      w_ring = RingTriple;
    end else if (w_d2 >= R2DoubleLo) begin
      w_ring = RingDouble;
    end
  end

  always_comb begin
    o_score = 6'd0;
    unique case (w_ring)
      RingBull50: o_score = 6'd50;
      RingBull25: o_score = 6'd25;
      RingMiss:   o_score = 6'd0;
      RingSingle: o_score = w_base;
      RingDouble: o_score = 6'(w_base << 1);
      RingTriple: o_score = 6'(w_base << 1) + w_base;
      default:    o_score = 6'd0;
    endcase
  end

`ifdef DOUBLE_OUT_EN
  assign o_is_double = (w_ring == RingDouble) || (w_ring == RingBull50);
`endif

endmodule

// File: rtl/dart_game_ctrl.sv
// Two-player 301 scoring and turn controller. Defining DOUBLE_OUT_EN requires a
// double or 50-bull to finish; otherwise any exact zero wins.
module dart_game_ctrl
  import dart_game_pkg::*;
#(
  parameter int unsigned START_PT = 301,
  parameter int unsigned CX       = 14,
  parameter int unsigned CY       = 14,
  parameter int unsigned DART_GAP = 2
) (
  input logic             clk,
  input logic             reset,
  dart_game_ctrl_if.slave bus
);

  state_e      r_state;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [5:0]  r_score;
  logic [8:0]  r_pt1;
  logic [8:0]  r_pt2;
  logic [8:0]  r_snap;
  logic        r_player;
  logic [1:0]  r_cnt;
  logic [3:0]  r_gap;
  logic        r_done1;
  logic        r_done2;
  logic        r_win1;
  logic        r_win2;
  logic        r_set;

  logic [5:0]        w_score;
  logic [8:0]        w_act_pt;
  logic [8:0]        w_oth_pt;
  logic [8:0]        w_next_pt;
  logic signed [9:0] w_rem;
  logic              w_win;
  logic              w_bust;
  logic              w_switch;

`ifdef DOUBLE_OUT_EN
  logic w_dbl;
  logic r_dbl;

  dart_score_lut #(
    .CX(CX),
    .CY(CY)
  ) u_lut (
    .i_x        (r_x),
    .i_y        (r_y),
    .o_is_double(w_dbl),
    .o_score    (w_score)
  );

  assign w_win  = (w_rem == 10'sd0) && r_dbl;
  assign w_bust = (w_rem < 10'sd0) || (w_rem == 10'sd1) || ((w_rem == 10'sd0) && !r_dbl);
`else
  dart_score_lut #(
    .CX(CX),
    .CY(CY)
  ) u_lut (
    .i_x    (r_x),
    .i_y    (r_y),
    .o_score(w_score)
  );

  assign w_win  = (w_rem == 10'sd0);
  assign w_bust = (w_rem < 10'sd0);
`endif

  assign w_act_pt = r_player ? r_pt2 : r_pt1;
  assign w_oth_pt = r_player ? r_pt1 : r_pt2;
  assign w_rem    = $signed({1'b0, w_act_pt}) - $signed({4'b0, r_score});

  always_comb begin
    w_next_pt = w_rem[8:0];
    w_switch  = (r_cnt == 2'd2);
    if (w_win) begin
      w_next_pt = 9'd0;
      w_switch  = 1'b0;
    end else if (w_bust) begin
      w_next_pt = r_snap;
      w_switch  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_x      <= 8'd0;
      r_y      <= 8'd0;
      r_score  <= 6'd0;
      r_pt1    <= 9'(START_PT);
      r_pt2    <= 9'(START_PT);
      r_snap   <= 9'(START_PT);
      r_player <= 1'b0;
      r_cnt    <= 2'd0;
      r_gap    <= 4'd0;
      r_done1  <= 1'b0;
      r_done2  <= 1'b0;
      r_win1   <= 1'b0;
      r_win2   <= 1'b0;
      r_set    <= 1'b0;
`ifdef DOUBLE_OUT_EN
      r_dbl    <= 1'b0;
`endif
    end else begin
      r_done1 <= 1'b0;
      r_done2 <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.dart_come_i) begin
            r_x     <= bus.dart_position_x_i;
            r_y     <= bus.dart_position_y_i;
            r_state <= StScore;
          end
        end
        StScore: begin
          r_score <= w_score;
`ifdef DOUBLE_OUT_EN
          r_dbl   <= w_dbl;
`endif
          r_state <= StUpdate;
        end
        StUpdate: begin
          r_done1 <= !r_player;
          r_done2 <= r_player;
          if (r_player) r_pt2 <= w_next_pt;
          else          r_pt1 <= w_next_pt;
          r_gap <= 4'd0;
          if (w_win) begin
            if (r_player) r_win2 <= 1'b1;
            else          r_win1 <= 1'b1;
            r_set   <= 1'b1;
            r_state <= StOver;
          end else begin
            r_state <= StGap;
            // The incoming player's current points become its bust fallback
            if (w_switch) begin
              r_player <= !r_player;
              r_cnt    <= 2'd0;
              r_snap   <= w_oth_pt;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        StGap: begin
          if (r_gap == 4'(DART_GAP - 1)) r_state <= StIdle;
          else                           r_gap   <= r_gap + 4'd1;
        end
        StOver: begin
          r_state <= StOver;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.game_set_o      = r_set;
  assign bus.player_1_done_o = r_done1;
  assign bus.player_2_done_o = r_done2;
  assign bus.player_1_win_o  = r_win1;
  assign bus.player_2_win_o  = r_win2;
  assign bus.player_1_pt_o   = r_pt1;
  assign bus.player_2_pt_o   = r_pt2;

endmodule

// File: tb/tb_dart_game_ctrl.sv
// Bench for dart_game_ctrl: three instances (301, 50 and 20 start points) checked
// against a rule-level game model under directed and random darts.
module tb_dart_game_ctrl;

  localparam int DartGap = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       come [3];
  logic [7:0] px = 8'd0;
  logic [7:0] py = 8'd0;

  logic       s_d1 [3];
  logic       s_d2 [3];
  logic       s_w1 [3];
  logic       s_w2 [3];
  logic       s_set[3];
  logic [8:0] s_p1 [3];
  logic [8:0] s_p2 [3];

  int n_checks = 0;
  int n_fail = 0;

  int m_pt    [3][2];
  int m_ts    [3];
  int m_player[3];
  int m_cnt   [3];
  bit m_win   [3][2];
  bit m_over  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dart_game_ctrl_if u_if ();
    assign u_if.dart_come_i       = come[g];
    assign u_if.dart_position_x_i = px;
    assign u_if.dart_position_y_i = py;
    assign s_d1[g]  = u_if.player_1_done_o;
    assign s_d2[g]  = u_if.player_2_done_o;
    assign s_w1[g]  = u_if.player_1_win_o;
    assign s_w2[g]  = u_if.player_2_win_o;
    assign s_set[g] = u_if.game_set_o;
    assign s_p1[g]  = u_if.player_1_pt_o;
    assign s_p2[g]  = u_if.player_2_pt_o;

    dart_game_ctrl #(
      .START_PT(g == 0 ? 301 : (g == 1 ? 50 : 20)),
      .CX      (14),
      .CY      (14),
      .DART_GAP(DartGap)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (u_if)
    );
  end

  function automatic int start_of(input int sel);
    return (sel == 0) ? 301 : ((sel == 1) ? 50 : 20);
  endfunction

  function automatic int sector(input int oct);
    case (oct)
      0: return 20;
      1: return 1;
      2: return 6;
      3: return 3;
      4: return 19;
      5: return 11;
      6: return 14;
      default: return 5;
    endcase
  endfunction

  // Dart points from the board geometry, using plain integer arithmetic
  function automatic void ref_score(input int x, input int y, output int pts, output bit dbl);
    int dx, dy, adx, ady, d2, q, oct, base;
    dx = x - 14;
    dy = 14 - y;
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    d2 = dx * dx + dy * dy;
    if (dx >= 0 && dy > 0) q = 0;
    else if (dx > 0 && dy <= 0) q = 1;
    else if (dx <= 0 && dy < 0) q = 2;
    else q = 3;
    if (q % 2 == 0) oct = (ady > adx) ? 2 * q : 2 * q + 1;
    else oct = (adx > ady) ? 2 * q : 2 * q + 1;
    base = sector(oct);
    dbl = 1'b0;
    if (d2 <= 1) begin
      pts = 50;
      dbl = 1'b1;
    end else if (d2 <= 4) pts = 25;
    else if (d2 > 169) pts = 0;
    else if (d2 >= 36 && d2 <= 49) pts = 3 * base;
    else if (d2 >= 144) begin
      pts = 2 * base;
      dbl = 1'b1;
    end else pts = base;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 3; s++) begin
      m_pt[s][0] = start_of(s);
      m_pt[s][1] = start_of(s);
      m_ts[s] = start_of(s);
      m_player[s] = 0;
      m_cnt[s] = 0;
      m_win[s][0] = 1'b0;
      m_win[s][1] = 1'b0;
      m_over[s] = 1'b0;
    end
  endfunction

  function automatic void next_turn(input int sel);
    m_player[sel] = 1 - m_player[sel];
    m_cnt[sel] = 0;
    m_ts[sel] = m_pt[sel][m_player[sel]];
  endfunction

  function automatic void model_apply(input int sel, input int pts, input bit dbl);
    int a, rem;
    bit win, bust;
    if (m_over[sel]) return;
    a = m_player[sel];
    rem = m_pt[sel][a] - pts;
`ifdef DOUBLE_OUT_EN
    win = (rem == 0) && dbl;
    bust = (rem < 0) || (rem == 1) || (rem == 0 && !dbl);
`else
    win = (rem == 0);
    bust = (rem < 0);
    if (dbl) win = win; // double flag only matters with double-out
`endif
    if (win) begin
      m_pt[sel][a] = 0;
      m_win[sel][a] = 1'b1;
      m_over[sel] = 1'b1;
    end else if (bust) begin
      m_pt[sel][a] = m_ts[sel];
      next_turn(sel);
    end else begin
      m_pt[sel][a] = rem;
      m_cnt[sel]++;
      if (m_cnt[sel] == 3) next_turn(sel);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < 3; s++) come[s] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One dart on instance sel; checks done timing, then points and flags against the model
  task automatic throw(input int sel, input int x, input int y, input string tag);
    int pts;
    bit dbl, e1, e2;
    ref_score(x, y, pts, dbl);
    e1 = !m_over[sel] && m_player[sel] == 0;
    e2 = !m_over[sel] && m_player[sel] == 1;
    @(negedge clk);
    px = 8'(x);
    py = 8'(y);
    come[sel] = 1'b1;
    @(negedge clk);
    come[sel] = 1'b0;
    n_checks++;
    if ({s_d1[sel], s_d2[sel]} !== 2'b00)
      $display("FAIL %s early_done1: dut%0d done=%b%b want 00", tag, sel, s_d1[sel], s_d2[sel]);
    @(negedge clk);
    n_checks++;
    if ({s_d1[sel], s_d2[sel]} !== 2'b00)
      $display("FAIL %s early_done2: dut%0d done=%b%b want 00", tag, sel, s_d1[sel], s_d2[sel]);
    @(negedge clk);
    n_checks++;
    if ({s_d1[sel], s_d2[sel]} !== {e1, e2}) begin
      n_fail++;
      $display("FAIL %s done: dut%0d done=%b%b want %b%b", tag, sel, s_d1[sel], s_d2[sel], e1, e2);
    end
    model_apply(sel, pts, dbl);
    n_checks++;
    if (s_p1[sel] !== 9'(m_pt[sel][0])) begin
      n_fail++;
      $display("FAIL %s pt1: dut%0d got %0d want %0d", tag, sel, s_p1[sel], m_pt[sel][0]);
    end
    n_checks++;
    if (s_p2[sel] !== 9'(m_pt[sel][1])) begin
      n_fail++;
      $display("FAIL %s pt2: dut%0d got %0d want %0d", tag, sel, s_p2[sel], m_pt[sel][1]);
    end
    n_checks++;
    if ({s_w1[sel], s_w2[sel], s_set[sel]} !== {m_win[sel][0], m_win[sel][1], m_over[sel]}) begin
      n_fail++;
      $display("FAIL %s flags: dut%0d win1/win2/set=%b%b%b want %b%b%b", tag, sel, s_w1[sel],
               s_w2[sel], s_set[sel], m_win[sel][0], m_win[sel][1], m_over[sel]);
    end
    @(negedge clk);
    n_checks++;
    if ({s_d1[sel], s_d2[sel]} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s pulse_width: dut%0d done=%b%b want 00", tag, sel, s_d1[sel], s_d2[sel]);
    end
    repeat (DartGap) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (s_p1[s] !== 9'(start_of(s)) || s_p2[s] !== 9'(start_of(s))) begin
        n_fail++;
        $display("FAIL reset_pt: dut%0d pt=%0d/%0d want %0d", s, s_p1[s], s_p2[s], start_of(s));
      end
      n_checks++;
      if ({s_d1[s], s_d2[s], s_w1[s], s_w2[s], s_set[s]} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_flags: dut%0d got %b%b%b%b%b want 00000", s, s_d1[s], s_d2[s],
                 s_w1[s], s_w2[s], s_set[s]);
      end
    end
  endtask

  task automatic test_first_dart();
    do_reset();
    throw(0, 14, 2, "first_dart");
    n_checks++;
    if (s_p1[0] !== 9'd261) begin
      n_fail++;
      $display("FAIL first_dart_261: got %0d want 261", s_p1[0]);
    end
  endtask

  task automatic test_reset_in_score();
    int pulses;
    @(negedge clk);
    px = 8'd14;
    py = 8'd8;
    come[0] = 1'b1;
    @(negedge clk);
    come[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_checks++;
    if (s_p1[0] !== 9'd301 || s_p2[0] !== 9'd301) begin
      n_fail++;
      $display("FAIL reset_in_score_pt: got %0d/%0d want 301/301", s_p1[0], s_p2[0]);
    end
    n_checks++;
    if ({s_d1[0], s_d2[0], s_w1[0], s_w2[0], s_set[0]} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_in_score_flags: got %b%b%b%b%b want 00000", s_d1[0], s_d2[0],
               s_w1[0], s_w2[0], s_set[0]);
    end
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_d1[0] || s_d2[0]) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_in_score_pulse: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_turn_switch();
    do_reset();
    throw(0, 14, 3, "turn_d1");
    throw(0, 14, 8, "turn_d2");
    throw(0, 14, 29, "turn_d3");
    n_checks++;
    if (s_p1[0] !== 9'd221) begin
      n_fail++;
      $display("FAIL turn_p1_221: got %0d want 221", s_p1[0]);
    end
    throw(0, 14, 2, "turn_p2");
    n_checks++;
    if (s_p2[0] !== 9'd261 || s_p1[0] !== 9'd221) begin
      n_fail++;
      $display("FAIL turn_p2_261: got %0d/%0d want 221/261", s_p1[0], s_p2[0]);
    end
  endtask

  task automatic test_bust();
    do_reset();
    throw(1, 14, 8, "bust");
    n_checks++;
    if (s_p1[1] !== 9'd50) begin
      n_fail++;
      $display("FAIL bust_pt: got %0d want 50", s_p1[1]);
    end
    throw(1, 14, 3, "after_bust");
    n_checks++;
    if (s_p2[1] !== 9'd30) begin
      n_fail++;
      $display("FAIL after_bust_p2: got %0d want 30", s_p2[1]);
    end
  endtask

  task automatic test_win();
    do_reset();
    throw(1, 14, 14, "win");
    n_checks++;
    if (s_w1[1] !== 1'b1 || s_set[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL win_flags: win1=%b set=%b want 1 1", s_w1[1], s_set[1]);
    end
    throw(1, 14, 3, "after_win");
    throw(1, 14, 2, "after_win2");
  endtask

`ifdef DOUBLE_OUT_EN
  task automatic test_double_out();
    do_reset();
    throw(2, 14, 3, "dout_single");
    n_checks++;
    if (s_p1[2] !== 9'd20) begin
      n_fail++;
      $display("FAIL dout_bust: got %0d want 20", s_p1[2]);
    end
    for (int i = 0; i < 3; i++) throw(2, 14, 29, "dout_p2_miss");
    throw(2, 13, 2, "dout_double");
    n_checks++;
    if (s_p1[2] !== 9'd10 || s_w1[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL dout_double: pt=%0d win=%b want 10 0", s_p1[2], s_w1[2]);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int got, cyc, pts, cx, cy, extra;
    bit dbl, e1, e2;
    do_reset();
    cx = $urandom_range(0, 28);
    cy = $urandom_range(0, 28);
    px = 8'(cx);
    py = 8'(cy);
    come[0] = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (s_d1[0] || s_d2[0]) begin
        ref_score(cx, cy, pts, dbl);
        e1 = !m_over[0] && m_player[0] == 0;
        e2 = !m_over[0] && m_player[0] == 1;
        n_checks++;
        if ({s_d1[0], s_d2[0]} !== {e1, e2}) begin
          n_fail++;
          $display("FAIL b2b_done: got %b%b want %b%b", s_d1[0], s_d2[0], e1, e2);
        end
        model_apply(0, pts, dbl);
        n_checks++;
        if (s_p1[0] !== 9'(m_pt[0][0]) || s_p2[0] !== 9'(m_pt[0][1])) begin
          n_fail++;
          $display("FAIL b2b_pt: got %0d/%0d want %0d/%0d", s_p1[0], s_p2[0], m_pt[0][0],
                   m_pt[0][1]);
        end
        got++;
        cx = $urandom_range(0, 28);
        cy = $urandom_range(0, 28);
        px = 8'(cx);
        py = 8'(cy);
      end
    end
    come[0] = 1'b0;
    n_checks++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d pulses want 6", got);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_d1[0] || s_d2[0]) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL b2b_extra: got %0d pulses want 0", extra);
    end
  endtask

  task automatic test_random(input int sel, input int n);
    int x, y;
    do_reset();
    for (int i = 0; i < n; i++) begin
      if (m_over[sel]) do_reset();
      if ($urandom_range(0, 3) != 0) begin
        x = $urandom_range(0, 28);
        y = $urandom_range(0, 28);
      end else begin
        x = $urandom_range(0, 255);
        y = $urandom_range(0, 255);
      end
      throw(sel, x, y, "random");
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) come[s] = 1'b0;
    model_reset();
    test_reset();
    test_first_dart();
    test_reset_in_score();
    test_turn_switch();
    test_bust();
    test_win();
`ifdef DOUBLE_OUT_EN
    test_double_out();
`endif
    test_back_to_back();
    test_random(0, 80);
    test_random(1, 60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
